// File: rtl/universal_shift_register.sv
// Parametrised load/shift/rotate register with a valid/ready bit serialiser.
// IDLE executes funct_i with 1-cycle latency; SEND shifts out WIDTH bits, one per accepted beat.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       funct_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] out_o,
  output logic             serial_o,
  output logic             ser_valid_o,
  input  logic             ser_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             state_o
);

  localparam logic [2:0] F_NOP  = 3'b000;
  localparam logic [2:0] F_LOAD = 3'b001;
  localparam logic [2:0] F_SHL  = 3'b010;
  localparam logic [2:0] F_SHR  = 3'b011;
  localparam logic [2:0] F_ROL  = 3'b100;
  localparam logic [2:0] F_ROR  = 3'b101;
  localparam logic [2:0] F_ASR  = 3'b110;
  localparam logic [2:0] F_SEND = 3'b111;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   q, q_next, op_q, ser_shift;
  logic [SHW-1:0]     count, count_next;
  logic               done_next;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] dbl, rol_w, ror_w;
  logic [WIDTH-1:0]   lo_mask, hi_mask;
  logic               fire, last;

  // Amount reduced mod WIDTH so non-power-of-2 widths never over-shift.
  assign amt     = SHW'(32'(shamt_i) % WIDTH);
  assign dbl     = {q, q};
  assign rol_w   = dbl << amt;
  assign ror_w   = dbl >> amt;
  assign lo_mask = ~({WIDTH{1'b1}} << amt);
  assign hi_mask = ~({WIDTH{1'b1}} >> amt);

  // Valid/ready: a beat transfers on an edge where ser_valid_o and ser_ready_i are both 1;
  // serial_o and ser_valid_o hold until that happens.
  assign fire = (state == SEND) && ser_ready_i;
  assign last = fire && (count == SHW'(WIDTH - 1));

  assign ser_shift = LSB_FIRST ? {serial_i, q[WIDTH-1:1]} : {q[WIDTH-2:0], serial_i};

  always_comb begin
    op_q = q;
    case (funct_i)
      F_NOP:  op_q = q;
      F_LOAD: op_q = word_i;
      F_SHL:  op_q = (q << amt) | (serial_i ? lo_mask : '0);
      F_SHR:  op_q = (q >> amt) | (serial_i ? hi_mask : '0);
      F_ROL:  op_q = rol_w[2*WIDTH-1:WIDTH];
      F_ROR:  op_q = ror_w[WIDTH-1:0];
      F_ASR:  op_q = WIDTH'($signed(q) >>> amt);
      F_SEND: op_q = word_i;
      default: op_q = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (funct_i == F_SEND) state_next = SEND;
      SEND: if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state == SEND);
    ser_valid_o = (state == SEND);
    state_o     = state;
  end

  always_comb begin
    q_next     = q;
    count_next = count;
    done_next  = 1'b0;
    if (state == IDLE) begin
      q_next     = op_q;
      count_next = '0;
    end else if (fire) begin
      q_next     = ser_shift;
      count_next = last ? '0 : count + SHW'(1);
      done_next  = last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      count  <= '0;
      done_o <= 1'b0;
    end else begin
      q      <= q_next;
      count  <= count_next;
      done_o <= done_next;
    end
  end

  assign out_o    = q;
  assign serial_o = LSB_FIRST ? q[0] : q[WIDTH-1];

endmodule
